// File: rtl/b2f_pkg.sv
// Shared widths, shift constants, FSM state and square-root stage record
// for the B-field to DDS tuning word calculator.
package b2f_pkg;
    localparam int B_W     = 32;
    localparam int K_W     = 8;
    localparam int R_W     = 80;
    localparam int S_W     = 40;
    localparam int N_W     = 72;
    localparam int A_SHIFT = 7;
    localparam int C_SHIFT = 14;
    localparam int N_SHIFT = 16;
    localparam int R_SHIFT = 32;
    localparam int REM_W   = S_W + 2;

    typedef enum logic {IDLE, BUSY} state_t;

    typedef struct packed {
        logic [REM_W-1:0] rem;
        logic [S_W-1:0]   root;
        logic [R_W-1:0]   rad;
    } sq_t;
endpackage

// File: rtl/isqrt_u80.sv
// Pipelined restoring integer square root: floor(sqrt(rad)), 80-bit radicand,
// 40-bit root, 5 result bits per stage, 8 clocks latency.
module isqrt_u80
    import b2f_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic [R_W-1:0] rad,
    output logic [S_W-1:0] root
);
    localparam int BITS_PER_STG = 5;
    localparam int STAGES       = S_W / BITS_PER_STG;

    // The remainder never exceeds 2*root, so its top two bits are zero before each shift.
    function automatic sq_t sq_step(input sq_t s);
        sq_t o;
        logic [REM_W-1:0] r, trial;
        o = s;
        for (int i = 0; i < BITS_PER_STG; i++) begin
            r     = {o.rem[REM_W-3:0], o.rad[R_W-1 -: 2]};
            trial = {o.root, 2'b01};
            o.rad = {o.rad[R_W-3:0], 2'b00};
            if (r >= trial) begin
                o.rem  = r - trial;
                o.root = {o.root[S_W-2:0], 1'b1};
            end else begin
                o.rem  = r;
                o.root = {o.root[S_W-2:0], 1'b0};
            end
        end
        return o;
    endfunction

    sq_t stg_in;
    sq_t stg [STAGES-1];
    sq_t last;
    logic unused_last;

    assign stg_in      = {{REM_W{1'b0}}, {S_W{1'b0}}, rad};
    assign last        = sq_step(stg[STAGES-2]);
    assign unused_last = ^{last.rem, last.rad};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STAGES-1; i++) stg[i] <= '0;
            root <= '0;
        end else begin
            stg[0] <= sq_step(stg_in);
            for (int i = 1; i < STAGES-1; i++) stg[i] <= sq_step(stg[i-1]);
            root <= last.root;
        end
    end
endmodule

// File: rtl/b_field_freq_calc.sv
// F = k*a*B/sqrt(b + c*B^2) as a DDS tuning word, fixed 13-clock latency.
// Optional B2F_SAT_EN: saturate overflow and S=0 to 0xFFFF_FFFF (else wrap / 0).
module b_field_freq_calc
    import b2f_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [B_W-1:0] b_field,
    input  logic [31:0]    a_coeff,
    input  logic [31:0]    b_coeff,
    input  logic [31:0]    c_coeff,
    input  logic [K_W-1:0] k_coeff,
    output logic [31:0]    freq,
    output logic           ready
);
    localparam int LATENCY = 13;
    localparam int SQ_LAT  = 8;
    localparam int Q1_W    = 13;
    localparam int T_W     = 79;
    localparam int ASH_W   = 32 + A_SHIFT;
    localparam int BSQ_W   = 2 * B_W;
    localparam int CSH_W   = 32 + C_SHIFT;
    localparam int PROD_W  = CSH_W + BSQ_W;
    localparam int QB_W    = Q1_W + B_W;
    localparam int QBK_W   = QB_W + K_W;
    localparam logic [ASH_W-1:0] CLK_DIV = ASH_W'(CLK_HZ);

    state_t state, state_nxt;
    logic [LATENCY-1:0] vld_pipe;
    logic accept, done;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: if (start) begin
                accept    = 1'b1;
                state_nxt = BUSY;
            end
            BUSY: if (done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign done = vld_pipe[LATENCY-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            vld_pipe <= '0;
        end else begin
            state    <= state_nxt;
            vld_pipe <= {vld_pipe[LATENCY-2:0], accept};
        end
    end

    // Input latch; the datapath below free-runs off these, so only the latch is gated.
    logic [B_W-1:0]    bf_l, bf1;
    logic [31:0]       a_l, b_l, c_l, b1, b2;
    logic [K_W-1:0]    k_l, k1, k2;
    logic [Q1_W-1:0]   q1_r;
    logic [BSQ_W-1:0]  bsq_r;
    logic [CSH_W-1:0]  csh_r;
    logic [T_W-1:0]    t_r;
    logic [QB_W-1:0]   qb_r;
    logic [R_W-1:0]    r_r;
    logic [N_W-1:0]    n_r;
    logic [N_W-1:0]    n_d [SQ_LAT];
    logic [N_W-1:0]    q_r;
    logic              s_zero_r;
    logic [S_W-1:0]    s_root;

    logic [ASH_W-1:0]  a_sh;
    logic [PROD_W-1:0] prod_c;
    logic [QBK_W-1:0]  qbk_c;
    logic              s_zero;
    logic [N_W-1:0]    q_c;
    logic [31:0]       res;

    assign a_sh   = {a_l, {A_SHIFT{1'b0}}};
    assign prod_c = PROD_W'(csh_r) * PROD_W'(bsq_r);
    assign qbk_c  = QBK_W'(qb_r) * QBK_W'(k2);
    assign s_zero = (s_root == '0);
    assign q_c    = n_d[SQ_LAT-1] / (s_zero ? N_W'(1) : N_W'(s_root));

`ifdef B2F_SAT_EN
    assign res = (s_zero_r || (|q_r[N_W-1:32])) ? 32'hFFFF_FFFF : q_r[31:0];
`else
    assign res = q_r[31:0];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bf_l <= '0; a_l <= '0; b_l <= '0; c_l <= '0; k_l <= '0;
            q1_r <= '0; bsq_r <= '0; csh_r <= '0; b1 <= '0; bf1 <= '0; k1 <= '0;
            t_r <= '0; qb_r <= '0; b2 <= '0; k2 <= '0;
            r_r <= '0; n_r <= '0;
            for (int i = 0; i < SQ_LAT; i++) n_d[i] <= '0;
            q_r <= '0; s_zero_r <= 1'b0;
            freq <= '0; ready <= 1'b0;
        end else begin
            if (accept) begin
                bf_l <= b_field; a_l <= a_coeff; b_l <= b_coeff;
                c_l  <= c_coeff; k_l <= k_coeff;
            end
            q1_r  <= Q1_W'(a_sh / CLK_DIV);
            bsq_r <= BSQ_W'(bf_l) * BSQ_W'(bf_l);
            csh_r <= {c_l, {C_SHIFT{1'b0}}};
            b1 <= b_l; bf1 <= bf_l; k1 <= k_l;
            t_r  <= T_W'(prod_c >> R_SHIFT);
            qb_r <= QB_W'(q1_r) * QB_W'(bf1);
            b2 <= b1; k2 <= k1;
            r_r <= (R_W'(b2) << R_SHIFT) + R_W'(t_r);
            n_r <= N_W'({qbk_c, {N_SHIFT{1'b0}}});
            // Align N with the square-root pipeline.
            n_d[0] <= n_r;
            for (int i = 1; i < SQ_LAT; i++) n_d[i] <= n_d[i-1];
            q_r      <= s_zero ? '0 : q_c;
            s_zero_r <= s_zero;
            if (done) begin
                freq  <= res;
                ready <= 1'b1;
            end else if (accept) begin
                ready <= 1'b0;
            end
        end
    end

    isqrt_u80 u_isqrt (
        .clk   (clk),
        .reset (reset),
        .rad   (r_r),
        .root  (s_root)
    );
endmodule

// File: tb/tb_b_field_freq_calc.sv
// Directed bench for b_field_freq_calc; expectations follow B2F_SAT_EN when defined.
module tb_b_field_freq_calc;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] b_field, a_coeff, b_coeff, c_coeff;
    logic [7:0]  k_coeff;
    logic [31:0] freq;
    logic        ready;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] A_NOM = 32'd100_000_000;
`ifdef B2F_SAT_EN
    localparam logic [31:0] EXP_SAT = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] EXP_SAT = 32'h0;
`endif

    always #5 clk = ~clk;

    b_field_freq_calc dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .b_field (b_field),
        .a_coeff (a_coeff),
        .b_coeff (b_coeff),
        .c_coeff (c_coeff),
        .k_coeff (k_coeff),
        .freq    (freq),
        .ready   (ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic [31:0] bf, a, b, c, input logic [7:0] k);
        b_field = bf; a_coeff = a; b_coeff = b; c_coeff = c; k_coeff = k;
    endtask

    // Pulse start for one edge (the accept edge); ready must drop there.
    task automatic launch(input string tag, input logic [31:0] bf, a, b, c, input logic [7:0] k);
        @(negedge clk);
        set_in(bf, a, b, c, k);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk({tag, "_rdy_clr"}, {31'b0, ready}, 32'd0);
    endtask

    // Ready must still be low at edge 12 and rise with the result at edge 13.
    task automatic expect_result(input string tag, input logic [31:0] exp);
        repeat (12) @(posedge clk);
        #1 chk({tag, "_rdy_early"}, {31'b0, ready}, 32'd0);
        @(posedge clk);
        #1 chk({tag, "_rdy"}, {31'b0, ready}, 32'd1);
        chk(tag, freq, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        set_in(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 chk("rst_freq", freq, 32'd0);
        chk("rst_ready", {31'b0, ready}, 32'd0);
        @(negedge clk) reset = 1'b0;

        launch("basic", 1, A_NOM, 1, 0, 1);
        expect_result("basic", 32'd128);

        launch("scale", 1000, A_NOM, 1, 0, 2);
        expect_result("scale", 32'd256000);

        launch("cterm", 65536, A_NOM, 0, 4, 1);
        expect_result("cterm", 32'h8000_0000);

        launch("bzero", 0, A_NOM, 1, 5, 3);
        expect_result("bzero", 32'd0);

        launch("ovf", 65536, A_NOM, 0, 1, 1);
        expect_result("ovf", EXP_SAT);

        launch("szero", 12345, A_NOM, 0, 0, 1);
        expect_result("szero", EXP_SAT);

        // Second start and changed inputs during BUSY must not disturb the first result.
        launch("midbusy", 1, A_NOM, 1, 0, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        set_in(1000, 32'd7, 9, 3, 2);
        start = 1'b1;
        repeat (4) @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        @(posedge clk);
        #1 chk("midbusy_rdy_early", {31'b0, ready}, 32'd0);
        @(posedge clk);
        #1 chk("midbusy_rdy", {31'b0, ready}, 32'd1);
        chk("midbusy", freq, 32'd128);
        @(posedge clk);
        #1 chk("midbusy_rdy_hold", {31'b0, ready}, 32'd1);

        // Start held high: completes, then re-triggers on the next edge.
        @(negedge clk);
        set_in(2, A_NOM, 1, 0, 1);
        start = 1'b1;
        @(posedge clk);
        repeat (13) @(posedge clk);
        #1 chk("held_rdy", {31'b0, ready}, 32'd1);
        chk("held", freq, 32'd256);
        @(posedge clk);
        #1 chk("held_retrig", {31'b0, ready}, 32'd0);
        start = 1'b0;
        repeat (13) @(posedge clk);
        #1 chk("held2_rdy", {31'b0, ready}, 32'd1);
        chk("held2", freq, 32'd256);

        // Reset in the middle of a calculation aborts at once.
        launch("abort", 1000, A_NOM, 1, 0, 2);
        repeat (6) @(posedge clk);
        #1 reset = 1'b1;
        #1 chk("abort_freq", freq, 32'd0);
        chk("abort_ready", {31'b0, ready}, 32'd0);
        @(negedge clk) reset = 1'b0;

        launch("after_rst", 1, A_NOM, 1, 0, 1);
        expect_result("after_rst", 32'd128);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
